serial_adder: RTL
=================

# serial_adder

Bit-serial N-bit adder: accepts two parallel operands on a start strobe, adds them LSB-first one bit per clock through a single full-adder cell and carry flip-flop, then presents the parallel sum and carry-out with a one-cycle done pulse. It is the addition counterpart to the combinational subtractor cells in the arithmetic library. It serves area-constrained datapaths that can trade latency for a single adder bit.

## Interface
- WIDTH, 8, operand and sum width in bits (≥2)
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  augend, captured on accepted start
- b  input  WIDTH  addend, captured on accepted start
- busy  output  1  high in RUN and DONE
- sum_bit  output  1  current serial sum bit (LSB first)
- sum_bit_valid  output  1  high during each RUN cycle
- done  output  1  one-cycle pulse when the result is available
- sum  output  WIDTH  result register (a+b) mod 2^WIDTH
- carry_out  output  1  carry out of bit WIDTH-1

## Operation
- One clock, clk. Reset is synchronous and active-high on rst.
- States: IDLE, RUN, DONE.
- IDLE: busy=0. On start=1, capture a and b into shift registers, clear carry FF, clear bit counter, and go to RUN.
- RUN: each cycle:
  - sum_bit = a_sh[0] ^ b_sh[0] ^ c.
  - New c = majority(a_sh[0], b_sh[0], c).
  - sum_bit shifts into the accumulator from the MSB side.
  - a_sh and b_sh shift right.
  - The counter increments.
  - After the cycle with count = WIDTH-1, go to DONE.
- DONE: copy the accumulator to sum and the final c to carry_out, pulse done, and return to IDLE next cycle.
- start is ignored in RUN and DONE. It is not queued. a and b changes after capture have no effect.
- sum and carry_out hold their last result until the next DONE overwrites them. They do not change during RUN.
- Arithmetic: {carry_out, sum} = a + b as an unsigned (WIDTH+1)-bit value. Two's-complement overflow is not flagged.
- Counter width is clog2(WIDTH).

## Timing
- Cycle 0: the edge that samples start=1 in IDLE.
- Cycles 1..WIDTH: RUN. sum_bit_valid=1 and sum_bit carries bit k-1 of the sum in cycle k.
- Cycle WIDTH+1: DONE. done=1, busy=1, and sum/carry_out are valid from this cycle.
- Cycle WIDTH+2: IDLE. The earliest next start is sampled here.
- Latency from start to done: WIDTH+1 cycles. Issue interval: WIDTH+2 cycles.
- Reset values: state=IDLE, busy=0, done=0, sum_bit=0, sum_bit_valid=0, sum=0, carry_out=0. Internal shift registers, carry and counter are also 0.
- rst has priority over start and over every state. Reset mid-RUN or in DONE aborts the operation with no done pulse, clears sum and carry_out, and returns to IDLE on the next edge.
- start asserted in the same cycle as rst is ignored.
- sum_bit is 0 whenever sum_bit_valid=0.

## Test plan
- WIDTH=8, a=0x3C, b=0x45, start for 1 cycle -> sum_bit sequence LSB-first 1,0,0,0,0,0,0,1; done exactly 9 cycles after start; sum=0x81, carry_out=0.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Then a=0xFF, b=0xFF -> sum=0xFE, carry_out=1. Also a=0x00, b=0x00 -> sum=0x00, carry_out=0, done still pulses.
- start=0x10+0x20, then start again with 0xAA+0x55 at cycles 3 and 9 (RUN/DONE) -> both ignored; single done with sum=0x30. Operands changed after cycle 0 do not affect the result.
- Hold start high continuously with a=0x01, b=0x02 -> operations every 10 cycles; done at cycles 9, 19, 29; sum=0x03 each time.
- Complete 0x7F+0x01 (sum=0x80), then start 0xF0+0xF0 and assert rst at cycle 4 -> next edge: busy=0, sum=0x00, carry_out=0, no done. A following 0x12+0x34 yields 0x46 with carry_out=0.
- Random sweep with WIDTH=8 and WIDTH=3 (all 64 pairs) against a+b -> every result and done timing match.

Source files
------------

// File: rtl/serial_adder_if.sv
// Bundle of the serial adder's request/result signals.
// The master side (requester) drives start and the operands.
// The slave side (the adder) drives status, the serial bit stream and the result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             sum_bit;
    logic             sum_bit_valid;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  sum_bit,
        input  sum_bit_valid,
        input  done,
        input  sum,
        input  carry_out
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output sum_bit,
        output sum_bit_valid,
        output done,
        output sum,
        output carry_out
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder.
// Two operands are captured on an accepted start. One full-adder cell then
// consumes one operand bit per clock, LSB first, with the carry held in a flop.
// The collected sum and the final carry are published for one DONE cycle,
// which carries a done pulse. They then hold until the next operation completes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    // A WIDTH of 2 or more keeps the counter and accumulator at least one bit wide.
    localparam int CW = $clog2(WIDTH);
    localparam int AW = WIDTH - 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Registered state and datapath.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             busy_q, busy_d;
    logic             sum_bit_valid_q, sum_bit_valid_d;
    logic             done_q, done_d;

    // The single full-adder cell and the shift networks feeding it.
    logic             fa_a;
    logic             fa_b;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] a_shr;
    logic [WIDTH-1:0] b_shr;
    logic [AW-1:0]    acc_ins;
    logic [WIDTH-1:0] result_full;

    assign fa_a     = a_sh_q[0];
    assign fa_b     = b_sh_q[0];
    assign fa_sum   = fa_a ^ fa_b ^ c_q;
    assign fa_carry = (fa_a & fa_b) | (fa_a & c_q) | (fa_b & c_q);

    // Operands move right by one position per RUN cycle, with zero filling the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_operand_shift
            if (gi == WIDTH - 1) begin : g_top
                assign a_shr[gi] = 1'b0;
                assign b_shr[gi] = 1'b0;
            end else begin : g_low
                assign a_shr[gi] = a_sh_q[gi+1];
                assign b_shr[gi] = b_sh_q[gi+1];
            end
        end
    endgenerate

    // The accumulator holds the first WIDTH-1 sum bits. New bits enter at the MSB,
    // so the oldest bit (bit 0 of the sum) lands at index 0 after WIDTH-1 shifts.
    generate
        for (gi = 0; gi < AW; gi++) begin : g_acc_shift
            if (gi == AW - 1) begin : g_top
                assign acc_ins[gi] = fa_sum;
            end else begin : g_low
                assign acc_ins[gi] = acc_q[gi+1];
            end
        end
    endgenerate

    // In the final RUN cycle the live full-adder output supplies the MSB.
    assign result_full = {fa_sum, acc_q};

    // Next-state and next-datapath logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d         = state_q;
        a_sh_d          = a_sh_q;
        b_sh_d          = b_sh_q;
        acc_d           = acc_q;
        c_d             = c_q;
        cnt_d           = cnt_q;
        sum_d           = sum_q;
        carry_out_d     = carry_out_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    acc_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sh_d = a_shr;
                b_sh_d = b_shr;
                acc_d  = acc_ins;
                c_d    = fa_carry;
                if (cnt_q == LAST_BIT) begin
                    // Publish on entry to DONE so the result is valid alongside done.
                    state_d     = DONE;
                    cnt_d       = '0;
                    sum_d       = result_full;
                    carry_out_d = fa_carry;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered images of the state being entered.
        busy_d          = (state_d != IDLE);
        sum_bit_valid_d = (state_d == RUN);
        done_d          = (state_d == DONE);
    end

    // State, datapath and status registers. Reset clears everything, including the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            a_sh_q          <= '0;
            b_sh_q          <= '0;
            acc_q           <= '0;
            c_q             <= 1'b0;
            cnt_q           <= '0;
            sum_q           <= '0;
            carry_out_q     <= 1'b0;
            busy_q          <= 1'b0;
            sum_bit_valid_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            a_sh_q          <= a_sh_d;
            b_sh_q          <= b_sh_d;
            acc_q           <= acc_d;
            c_q             <= c_d;
            cnt_q           <= cnt_d;
            sum_q           <= sum_d;
            carry_out_q     <= carry_out_d;
            busy_q          <= busy_d;
            sum_bit_valid_q <= sum_bit_valid_d;
            done_q          <= done_d;
        end
    end

    // The serial bit is the live full-adder output, forced low outside RUN.
    assign bus.sum_bit       = sum_bit_valid_q & fa_sum;
    assign bus.sum_bit_valid = sum_bit_valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.sum           = sum_q;
    assign bus.carry_out     = carry_out_q;

endmodule
